// File: rtl/decode_pipe_pkg.sv
// ---------------------------------------------------------------
// decode_pipe_pkg : shared RV32I decode types and constants
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package decode_pipe_pkg;

  typedef enum logic [2:0] {
    IT_R       = 3'd0,
    IT_I       = 3'd1,
    IT_S       = 3'd2,
    IT_B       = 3'd3,
    IT_U       = 3'd4,
    IT_J       = 3'd5,
    IT_ILLEGAL = 3'd6
  } insn_type_t;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [31:0] INSN_NOP       = 32'h0000_0013;
  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/decode_pipe_if.sv
// ---------------------------------------------------------------
// decode_pipe_if : fetch-side and decode-side handshake bundle
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface decode_pipe_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 2
) ();
  import decode_pipe_pkg::*;

  logic                     flush_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [AWIDTH-1:0]        pc_i;
  logic [DWIDTH-1:0]        insn_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [AWIDTH-1:0]        pc_o;
  logic [DWIDTH-1:0]        insn_o;
  logic [6:0]               opcode_o;
  logic [4:0]               rd_o;
  logic [4:0]               rs1_o;
  logic [4:0]               rs2_o;
  logic [2:0]               funct3_o;
  logic [6:0]               funct7_o;
  logic [4:0]               shamt_o;
  logic [DWIDTH-1:0]        imm_o;
  insn_type_t               itype_o;
  logic                     illegal_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport master (
    output flush_i, valid_i, pc_i, insn_i, ready_i,
    input  ready_o, valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, shamt_o, imm_o, itype_o, illegal_o, count_o
  );

  modport slave (
    input  flush_i, valid_i, pc_i, insn_i, ready_i,
    output ready_o, valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, shamt_o, imm_o, itype_o, illegal_o, count_o
  );

endinterface

`default_nettype wire

// File: rtl/decode_pipe_igen.sv
// ---------------------------------------------------------------
// igen : RV32I sign-extended immediate generator
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module igen
  import decode_pipe_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [6:0]        opcode_i,
  input  logic [DWIDTH-1:0] insn_i,
  output logic [DWIDTH-1:0] imm_o
);

  logic [31:0] imm32_d;
  logic        w_unused;

  assign w_unused = ^insn_i[6:0];

  always_comb begin
    imm32_d = '0;
    case (opcode_i)
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_MISCMEM, OPC_SYSTEM:
        imm32_d = {{20{insn_i[31]}}, insn_i[31:20]};
      OPC_STORE:
        imm32_d = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      OPC_BRANCH:
        imm32_d = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32_d = {insn_i[31:12], 12'h000};
      OPC_JAL:
        imm32_d = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
      default:
        imm32_d = '0;
    endcase
  end

  generate
    if (DWIDTH > 32) begin : g_wide
      assign imm_o = {{(DWIDTH-32){imm32_d[31]}}, imm32_d};
    end else begin : g_exact
      assign imm_o = imm32_d[DWIDTH-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/decode_pipe.sv
// ---------------------------------------------------------------
// decode_pipe : small in-order buffer presenting a decoded RV32I head
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(IMEM_BASE_ADDR)
) (
  input logic         clk,
  input logic         rst,
  decode_pipe_if.slave pipe
);

  localparam int PW = $clog2(DEPTH);

  logic [AWIDTH-1:0] pc_mem_q   [DEPTH];
  logic [DWIDTH-1:0] insn_mem_q [DEPTH];
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;
  logic [PW:0]       count_q;

  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [DWIDTH-1:0] w_insn;
  logic [6:0]        w_opcode;
  insn_type_t        w_itype;

  assign w_valid = (count_q != '0);
  assign w_push  = pipe.valid_i && pipe.ready_o && !pipe.flush_i;
  assign w_pop   = w_valid && pipe.ready_i && !pipe.flush_i;

  always_ff @(posedge clk) begin
    if (rst || pipe.flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop)  rptr_q <= rptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is left unreset; pointers and count alone define occupancy.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      pc_mem_q[wptr_q]   <= pipe.pc_i;
      insn_mem_q[wptr_q] <= pipe.insn_i;
    end
  end

  assign w_insn   = w_valid ? insn_mem_q[rptr_q] : DWIDTH'(INSN_NOP);
  assign w_opcode = w_insn[6:0];

  always_comb begin
    w_itype = IT_ILLEGAL;
    case (w_opcode)
      OPC_OP:                                                   w_itype = IT_R;
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_MISCMEM, OPC_SYSTEM:   w_itype = IT_I;
      OPC_STORE:                                                w_itype = IT_S;
      OPC_BRANCH:                                               w_itype = IT_B;
      OPC_LUI, OPC_AUIPC:                                       w_itype = IT_U;
      OPC_JAL:                                                  w_itype = IT_J;
      default:                                                  w_itype = IT_ILLEGAL;
    endcase
  end

  igen #(.DWIDTH(DWIDTH)) u_igen (
    .opcode_i (w_opcode),
    .insn_i   (w_insn),
    .imm_o    (pipe.imm_o)
  );

  assign pipe.ready_o   = (count_q < (PW+1)'(DEPTH));
  assign pipe.valid_o   = w_valid;
  assign pipe.count_o   = count_q;
  assign pipe.pc_o      = w_valid ? pc_mem_q[rptr_q] : RESET_PC;
  assign pipe.insn_o    = w_insn;
  assign pipe.opcode_o  = w_opcode;
  assign pipe.rd_o      = w_insn[11:7];
  assign pipe.funct3_o  = w_insn[14:12];
  assign pipe.rs1_o     = w_insn[19:15];
  assign pipe.rs2_o     = w_insn[24:20];
  assign pipe.shamt_o   = w_insn[24:20];
  assign pipe.funct7_o  = w_insn[31:25];
  assign pipe.itype_o   = w_itype;
  assign pipe.illegal_o = w_valid && (w_itype == IT_ILLEGAL);

endmodule

`default_nettype wire

// File: tb/tb_decode_pipe.sv
// ---------------------------------------------------------------
// tb_decode_pipe : scoreboard bench for decode_pipe
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_decode_pipe;
  import decode_pipe_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] imm;
    insn_type_t  itype;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  bit   done = 1'b0;
  int   nvec = 0;
  int   nmis = 0;
  exp_t sb[$];

  // Hand-decoded table used across the pointer-wrap run
  logic [31:0] tbl_insn [8] = '{32'h002081B3, 32'hFE512E23, 32'h008000EF, 32'hFFFFF197,
                                32'h00008067, 32'hFFF10093, 32'hFE000EE3, 32'h123452B7};
  logic [31:0] tbl_imm  [8] = '{32'h00000000, 32'hFFFFFFFC, 32'h00000008, 32'hFFFFF000,
                                32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000};
  insn_type_t  tbl_it   [8] = '{IT_R, IT_S, IT_J, IT_U, IT_I, IT_I, IT_B, IT_U};

  always #5 clk = ~clk;

  decode_pipe_if #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) pipe ();

  decode_pipe #(
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (AW'(IMEM_BASE_ADDR))
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (pipe)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] insn, input logic [31:0] imm,
                      input insn_type_t it, input bit track);
    int n = 0;
    pipe.valid_i = 1'b1;
    pipe.pc_i    = pc;
    pipe.insn_i  = insn;
    while (!pipe.ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      nvec++; nmis++;
      $display("FAIL push_timeout: ready_o got 0, required 1");
    end else if (track) begin
      sb.push_back('{pc, insn, imm, it, 1'(it == IT_ILLEGAL)});
    end
    @(posedge clk); #1;
    pipe.valid_i = 1'b0;
  endtask

  // Monitor: every accepted head is checked against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && pipe.valid_o && pipe.ready_i && !pipe.flush_i) begin
      if (sb.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL unexpected_pop: got insn %h, required no entry", pipe.insn_o);
      end else begin
        e = sb.pop_front();
        chk("sb_pc",      pipe.pc_o,      e.pc);
        chk("sb_insn",    pipe.insn_o,    e.insn);
        chk("sb_imm",     pipe.imm_o,     e.imm);
        chk("sb_itype",   pipe.itype_o,   e.itype);
        chk("sb_illegal", pipe.illegal_o, e.ill);
      end
    end
  end

  initial begin
    int k;
    rst          = 1'b1;
    pipe.flush_i = 1'b0;
    pipe.ready_i = 1'b0;
    pipe.valid_i = 1'b1;
    pipe.pc_i    = 32'hDEAD0000;
    pipe.insn_i  = 32'h002081B3;
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b0;
    pipe.valid_i = 1'b0;

    chk("rst_valid",   pipe.valid_o,   0);
    chk("rst_ready",   pipe.ready_o,   1);
    chk("rst_count",   pipe.count_o,   0);
    chk("rst_insn",    pipe.insn_o,    32'h00000013);
    chk("rst_pc",      pipe.pc_o,      IMEM_BASE_ADDR);
    chk("rst_illegal", pipe.illegal_o, 0);
    chk("rst_itype",   pipe.itype_o,   IT_I);
    chk("rst_imm",     pipe.imm_o,     0);

    // Latency-1 presentation of an I-type
    push(32'h01000000, 32'hFFF10093, 32'hFFFFFFFF, IT_I, 1'b1);
    chk("i_valid",  pipe.valid_o,  1);
    chk("i_count",  pipe.count_o,  1);
    chk("i_pc",     pipe.pc_o,     32'h01000000);
    chk("i_rd",     pipe.rd_o,     1);
    chk("i_rs1",    pipe.rs1_o,    2);
    chk("i_funct3", pipe.funct3_o, 0);
    chk("i_opcode", pipe.opcode_o, 7'h13);
    chk("i_imm",    pipe.imm_o,    32'hFFFFFFFF);
    chk("i_itype",  pipe.itype_o,  IT_I);
    pipe.ready_i = 1'b1;
    @(posedge clk); #1;
    chk("i_drained", pipe.count_o, 0);

    // Fill to full while stalled, then pop-only and push+pop
    pipe.ready_i = 1'b0;
    push(32'h01000004, 32'h123452B7, 32'h12345000, IT_U, 1'b1);
    push(32'h01000008, 32'hFE000EE3, 32'hFFFFFFFC, IT_B, 1'b1);
    chk("full_count", pipe.count_o, 2);
    chk("full_ready", pipe.ready_o, 0);
    pipe.ready_i = 1'b1;
    pipe.valid_i = 1'b1;
    pipe.pc_i    = 32'h0100000C;
    pipe.insn_i  = 32'h00A00513;
    @(posedge clk); #1;
    chk("poponly_count", pipe.count_o, 1);
    chk("poponly_ready", pipe.ready_o, 1);
    sb.push_back('{32'h0100000C, 32'h00A00513, 32'h0000000A, IT_I, 1'b0});
    @(posedge clk); #1;
    chk("pushpop_count", pipe.count_o, 1);
    pipe.valid_i = 1'b0;
    @(posedge clk); #1;
    chk("drain_count", pipe.count_o, 0);

    // Flush overrides same-cycle push and pop
    pipe.ready_i = 1'b0;
    push(32'h00004000, 32'h002081B3, 32'h0, IT_R, 1'b0);
    push(32'h00004004, 32'hFE512E23, 32'h0, IT_S, 1'b0);
    chk("preflush_count", pipe.count_o, 2);
    pipe.flush_i = 1'b1;
    pipe.valid_i = 1'b1;
    pipe.ready_i = 1'b1;
    pipe.pc_i    = 32'h00004008;
    pipe.insn_i  = 32'h008000EF;
    @(posedge clk); #1;
    pipe.flush_i = 1'b0;
    pipe.valid_i = 1'b0;
    pipe.ready_i = 1'b0;
    chk("flush_count", pipe.count_o, 0);
    chk("flush_valid", pipe.valid_o, 0);
    chk("flush_insn",  pipe.insn_o,  32'h00000013);
    chk("flush_pc",    pipe.pc_o,    IMEM_BASE_ADDR);

    // Illegal opcode
    push(32'h00005000, 32'h0000007F, 32'h0, IT_ILLEGAL, 1'b1);
    chk("ill_flag",  pipe.illegal_o, 1);
    chk("ill_itype", pipe.itype_o,   IT_ILLEGAL);
    chk("ill_imm",   pipe.imm_o,     0);
    pipe.ready_i = 1'b1;
    @(posedge clk); #1;

    // Ordered stream across pointer wrap with random back-pressure
    fork
      begin
        for (int i = 0; i < 8; i++)
          push(32'h00003000 + 32'(4 * i), tbl_insn[i], tbl_imm[i], tbl_it[i], 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          pipe.ready_i = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    pipe.ready_i = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("wrap_left",  sb.size(), 0);
    chk("wrap_count", pipe.count_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
